// File: rtl/step_sequence_scheduler.sv
// step_sequence_scheduler: step-tick divider, step/loop walker, pattern fetch and gate driver for the sequencer
module step_sequence_scheduler #(
  parameter int STEPS = 16,
  parameter int NOTES = 8,
  parameter int DIV_W = 24,
  localparam int IDX_W = $clog2(STEPS)
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             StartPulse,
  input  logic             StopPulse,
  input  logic             PausePulse,
  input  logic [DIV_W-1:0] StepPeriod,
  input  logic [7:0]       Loops,
  output logic [IDX_W-1:0] PatAddr,
  input  logic [NOTES-1:0] PatRdData,
  output logic [IDX_W-1:0] StepIndex,
  output logic [7:0]       LoopCount,
  output logic             StepTick,
  output logic [NOTES-1:0] Gate,
  output logic             Play,
  output logic             Done
);
  typedef enum logic [1:0] {IDLE, PREP, RUN, PAUSE} state_t;
  state_t state, state_nx;
  logic [DIV_W-1:0] period, divider, half;
  logic [7:0] loop_tgt, loop_count, loop_inc;
  logic [IDX_W-1:0] step_index, pat_addr;
  logic [NOTES-1:0] pat_reg;
  logic done, resumed, adv, pause_req, step_start, boundary, wrap, finish, load;
  assign adv = state == RUN && !StopPulse && !StartPulse && !PausePulse;
  assign pause_req = PausePulse && (state == RUN || state == PAUSE);
  assign step_start = state == RUN && divider == '0;
  assign boundary = adv && divider == period - DIV_W'(1);
  assign wrap = boundary && step_index == IDX_W'(STEPS - 1);
  assign loop_inc = (loop_count == 8'hff) ? loop_count : loop_count + 8'd1;
  assign finish = wrap && loop_tgt != '0 && loop_inc == loop_tgt;
  assign half = ((period >> 1) == '0) ? DIV_W'(1) : period >> 1;
  // after resuming on a step start the fetched word has moved on, so use the held copy
  assign load = step_start && !resumed && !StopPulse && !StartPulse;
  always_comb begin
    state_nx = StopPulse ? IDLE :
               StartPulse ? PREP :
               state == PREP ? RUN :
               pause_req ? (state == RUN ? PAUSE : RUN) :
               finish ? IDLE : state;
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      period     <= DIV_W'(1);
      loop_tgt   <= '0;
      divider    <= '0;
      step_index <= '0;
      loop_count <= '0;
      pat_addr   <= '0;
      pat_reg    <= '0;
      done       <= 1'b0;
      resumed    <= 1'b0;
    end else begin
      state   <= state_nx;
      done    <= finish;
      resumed <= state == PAUSE && state_nx == RUN;
      if (StopPulse || StartPulse) begin
        divider    <= '0;
        step_index <= '0;
        loop_count <= '0;
        pat_addr   <= '0;
        pat_reg    <= '0;
      end else begin
        if (state == PREP) begin
          period   <= (StepPeriod == '0) ? DIV_W'(1) : StepPeriod;
          loop_tgt <= Loops;
          pat_addr <= IDX_W'(1);
        end
        if (load) pat_reg <= PatRdData;
        if (adv) begin
          if (boundary) begin
            divider    <= '0;
            step_index <= step_index + IDX_W'(1);
            pat_addr   <= finish ? '0 : step_index + IDX_W'(2);
            if (wrap) loop_count <= loop_inc;
          end else begin
            divider <= divider + DIV_W'(1);
          end
        end
      end
    end
  end
  assign PatAddr   = pat_addr;
  assign StepIndex = step_index;
  assign LoopCount = loop_count;
  assign StepTick  = step_start;
  assign Gate      = (state == RUN && divider < half) ? ((step_start && !resumed) ? PatRdData : pat_reg) : '0;
  assign Play      = state == PREP || state == RUN;
  assign Done      = done;
endmodule

// File: doc/step_sequence_scheduler.md
Name: step_sequence_scheduler

Overview:
Top-level playback controller for the 16-step piano sequencer. It derives the step tick from a programmable clock-cycle period and walks the step index. It fetches each step's note pattern from the pattern memory and drives the per-note gate outputs. It also counts loops, handles start/stop/pause controls, and signals completion when the programmed number of loops has played.

Parameters:
STEPS, 16, steps per loop (power of two); index width IDX_W = log2(STEPS) = 4
NOTES, 8, number of note lanes (width of pattern word and Gate)
DIV_W, 24, width of step period in clock cycles

Ports:
Clock  input  1  system clock, all state on rising edge
nReset  input  1  asynchronous active-low reset
StartPulse  input  1  one-cycle request: (re)start playback from step 0, loop 0
StopPulse  input  1  one-cycle request: abort playback
PausePulse  input  1  one-cycle request: toggle RUN <-> PAUSE
StepPeriod  input  DIV_W  clock cycles per step; sampled at start; 0 treated as 1
Loops  input  8  loops to play; sampled at start; 0 = infinite
PatAddr  output  IDX_W  pattern memory read address
PatRdData  input  NOTES  pattern word; valid one cycle after PatAddr (synchronous RAM)
StepIndex  output  IDX_W  current step
LoopCount  output  8  completed loops, saturates at 255
StepTick  output  1  one-cycle pulse on the first cycle of every step
Gate  output  NOTES  note-on per lane
Play  output  1  high in PREP and RUN
Done  output  1  one-cycle pulse at natural end of final loop

Behaviour:
- Reset (async, nReset=0): state IDLE; StepIndex=0, LoopCount=0, PatAddr=0, StepTick=0, Gate=0, Play=0, Done=0, divider=0.
- States: IDLE, PREP, RUN, PAUSE.
- Priority when pulses coincide: StopPulse > StartPulse > PausePulse.
- IDLE: outputs idle. StartPulse -> PREP. PausePulse is ignored.
- PREP (exactly 1 cycle):
  - Latch period P = max(StepPeriod, 1) and loop target L = Loops.
  - Drive PatAddr=0; clear StepIndex, LoopCount and divider.
  - Play=1. Next state RUN.
- RUN, step start (first RUN cycle and every boundary):
  - StepTick=1.
  - Pattern register <= PatRdData; Gate is derived from it (registered, see gate window below).
  - PatAddr <= (StepIndex+1) mod STEPS, so the next word is valid by the next boundary even when P=1.
- RUN, divider:
  - Counts 0..P-1. A boundary occurs on the cycle where divider==P-1.
  - At the boundary, StepIndex increments mod STEPS and divider clears.
- Gate window:
  - Gate = pattern register while divider < H, where H = max(P>>1, 1); Gate=0 otherwise.
  - P=1: Gate is high every cycle.
- Loop wrap (boundary with StepIndex==STEPS-1):
  - LoopCount increments, saturating at 255.
  - If L!=0 and the new LoopCount==L: next state IDLE, Done=1 for one cycle, Play=0, Gate=0, StepIndex=0, StepTick not asserted.
  - Otherwise continue at step 0. Total steps played = STEPS*L.
- L=0: never finishes; LoopCount saturates at 255 and playback continues.
- PausePulse in RUN -> PAUSE:
  - Divider, StepIndex, PatAddr and LoopCount freeze.
  - Gate=0, Play=0.
  - PausePulse in PAUSE -> RUN, resuming at the frozen divider value. No StepTick unless resuming exactly on a boundary cycle.
  - Pattern register is retained.
- StopPulse in any non-IDLE state -> IDLE next cycle. All outputs return to reset values; no Done.
- StartPulse in RUN or PAUSE -> PREP (full restart; new StepPeriod/Loops sampled).
- StepPeriod and Loops changes outside PREP have no effect until the next start.
- nReset mid-playback: immediate return to reset values; no Done.

Test Plan:
- Reset, then StartPulse with StepPeriod=4, Loops=1, pattern word k = k+1 -> PREP 1 cycle; 16 StepTicks 4 cycles apart; Gate equals k+1 for 2 cycles of each step; Done pulses once 64 cycles after first StepTick; Play falls with Done.
- StepPeriod=0, Loops=2 -> behaves as P=1; StepTick and Gate every cycle; PatAddr leads StepIndex by 1; Done after 32 steps; LoopCount=2 at end.
- Loops=0, StepPeriod=2, run 300 loops -> Done never asserts; LoopCount saturates at 255; StepIndex keeps wrapping 15->0.
- PausePulse at divider=1 of step 5 with P=4, hold 10 cycles, PausePulse again -> Gate=0 and Play=0 while paused; step 5 resumes at divider=1; next StepTick after 2 cycles; total run time extended by exactly 10 cycles plus the pause/resume overhead.
- StopPulse and StartPulse in the same cycle during RUN -> IDLE, no Done, all outputs zero; a later StartPulse alone restarts from step 0.
- nReset asserted mid-step 9 of loop 0 -> outputs zero immediately (asynchronous); after release, remain in IDLE with no StepTick.
